// File: rtl/core_mem_arbiter.sv
// Arbitrates the core's fetch and data ports onto one request/ack memory bus.
// Data has priority; fetch is forced after STARVE consecutive data wins; a watchdog bounds each access.
module core_mem_arbiter #(
  parameter int TIMEOUT = 255,
  parameter int STARVE  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_rd_i,
  input  logic [31:0] inst_addr_i,
  output logic [31:0] inst_data_o,
  output logic        inst_valid_o,
  input  logic        data_rd_i,
  input  logic        data_we_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_data_i,
  input  logic [1:0]  data_sel_i,
  output logic [31:0] data_data_o,
  output logic        data_valid_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_data_o,
  output logic [1:0]  bus_sel_o,
  output logic        bus_rd_o,
  output logic        bus_we_o,
  input  logic [31:0] bus_data_i,
  input  logic        bus_ack_i,
  output logic        bus_err_o
);

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);
  localparam logic [3:0] STARVE_C  = 4'(STARVE);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  state_t      state_reg;
  logic        owner_inst_reg;
  logic [7:0]  tmo_cnt_reg;
  logic [3:0]  starve_cnt_reg;

  logic data_req;
  logic grant_inst;
  logic grant_data;

  always_comb begin
    data_req   = data_rd_i || data_we_i;
    grant_inst = inst_rd_i && (!data_req || (starve_cnt_reg == STARVE_C));
    grant_data = data_req && !grant_inst;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      owner_inst_reg <= 1'b0;
      tmo_cnt_reg    <= '0;
      starve_cnt_reg <= '0;
      inst_data_o    <= '0;
      inst_valid_o   <= 1'b0;
      data_data_o    <= '0;
      data_valid_o   <= 1'b0;
      bus_addr_o     <= '0;
      bus_data_o     <= '0;
      bus_sel_o      <= '0;
      bus_rd_o       <= 1'b0;
      bus_we_o       <= 1'b0;
      bus_err_o      <= 1'b0;
    end else begin
      // Completion pulses last exactly one cycle (the RESP cycle).
      inst_valid_o <= 1'b0;
      data_valid_o <= 1'b0;
      bus_err_o    <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (grant_inst) begin
            owner_inst_reg <= 1'b1;
            bus_addr_o     <= inst_addr_i;
            bus_data_o     <= '0;
            bus_sel_o      <= '0;
            bus_rd_o       <= 1'b1;
            bus_we_o       <= 1'b0;
            starve_cnt_reg <= '0;
            tmo_cnt_reg    <= '0;
            state_reg      <= BUS;
          end else if (grant_data) begin
            owner_inst_reg <= 1'b0;
            bus_addr_o     <= data_addr_i;
            bus_data_o     <= data_data_i;
            bus_sel_o      <= data_sel_i;
            bus_rd_o       <= data_rd_i;
            bus_we_o       <= data_we_i;
            if (inst_rd_i && (starve_cnt_reg != STARVE_C))
              starve_cnt_reg <= starve_cnt_reg + 4'd1;
            tmo_cnt_reg    <= '0;
            state_reg      <= BUS;
          end
        end
        BUS: begin
          if (bus_ack_i) begin
            bus_rd_o <= 1'b0;
            bus_we_o <= 1'b0;
            if (owner_inst_reg) begin
              inst_data_o  <= bus_data_i;
              inst_valid_o <= 1'b1;
            end else begin
              if (bus_rd_o)
                data_data_o <= bus_data_i;
              data_valid_o <= 1'b1;
            end
            state_reg <= RESP;
          end else if (tmo_cnt_reg == TIMEOUT_C) begin
            // Dead bus: complete with zero data and flag the error.
            bus_rd_o  <= 1'b0;
            bus_we_o  <= 1'b0;
            bus_err_o <= 1'b1;
            if (owner_inst_reg) begin
              inst_data_o  <= '0;
              inst_valid_o <= 1'b1;
            end else begin
              data_data_o  <= '0;
              data_valid_o <= 1'b1;
            end
            state_reg <= RESP;
          end else begin
            tmo_cnt_reg <= tmo_cnt_reg + 8'd1;
          end
        end
        RESP: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/core_mem_arbiter.md
# core_mem_arbiter

Two-port to one-port memory arbiter sitting between `core` and the shared memory bus. It multiplexes the core's instruction-fetch port and data port onto a single request/acknowledge bus, gives data accesses priority with bounded instruction starvation, and returns a one-cycle `valid` pulse to whichever port was served. A bus watchdog turns a missing acknowledge into an error completion so the core's pipeline can never hang on a dead bus.

## Interface
Parameters:
- `TIMEOUT`, 255: max cycles in BUS before forced completion (1..255, 8-bit counter).
- `STARVE`, 4: consecutive data grants with instruction pending before instruction is forced (1..15).

Ports:
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `inst_rd_i`  in  1  instruction fetch request; held until `inst_valid_o`.
- `inst_addr_i`  in  32  fetch address; stable while request held.
- `inst_data_o`  out  32  fetched word; meaningful when `inst_valid_o`.
- `inst_valid_o`  out  1  one-cycle completion pulse for fetch.
- `data_rd_i`  in  1  data load request.
- `data_we_i`  in  1  data store request (`data_rd_i` and `data_we_i` never both 1).
- `data_addr_i`  in  32  data address.
- `data_data_i`  in  32  store data.
- `data_sel_i`  in  2  access size code, passed through unchanged.
- `data_data_o`  out  32  load result; meaningful when `data_valid_o`.
- `data_valid_o`  out  1  one-cycle completion pulse for load or store.
- `bus_addr_o`  out  32  bus address.
- `bus_data_o`  out  32  bus write data.
- `bus_sel_o`  out  2  bus size code.
- `bus_rd_o`  out  1  bus read strobe.
- `bus_we_o`  out  1  bus write strobe.
- `bus_data_i`  in  32  bus read data, valid with `bus_ack_i`.
- `bus_ack_i`  in  1  bus completion, one cycle.
- `bus_err_o`  out  1  one-cycle pulse coincident with a timed-out completion.

## Operation
- States: IDLE, BUS, RESP. Reset → IDLE; all outputs 0, starve counter 0, timeout counter 0.
- IDLE: sample requests. Grant selection: if only one port requests, grant it. If both request: grant instruction when starve counter == `STARVE`, else grant data. No request → stay IDLE.
- On grant: register owner, address, write data, sel; drive `bus_rd_o` (fetch or load) or `bus_we_o` (store); go BUS; clear timeout counter.
- Starve counter: increments (saturating at `STARVE`) on each data grant made while `inst_rd_i` is high; clears on every instruction grant; unchanged on data grant with no fetch pending.
- BUS: strobes, address, data, sel held constant. On `bus_ack_i`: latch `bus_data_i` into owner's data output (stores latch nothing, `data_data_o` keeps old value), drop strobes, go RESP. Else increment timeout counter; when it reaches `TIMEOUT`, drop strobes, set owner's data output to 32'h00000000, go RESP with error flag.
- RESP: owner's `*_valid_o` high for exactly this cycle; `bus_err_o` high this cycle iff timed out. Next state IDLE unconditionally.
- A request present in the cycle after RESP is a new request (core has advanced); same-port back-to-back requests are legal.
- `bus_ack_i` in IDLE or RESP is ignored.
- `rst` in any state: next edge forces IDLE, strobes and valids to 0, counters to 0; in-flight access is abandoned without completion.

## Timing
- Request sampled in IDLE at cycle N → strobe high at N+1.
- Ack at cycle M (M ≥ N+1) → strobes low and `*_valid_o` high at M+1 → IDLE at M+2.
- Minimum turnaround: 3 cycles per access (zero-wait ack at N+1: valid at N+2, next grant sampled N+3).
- Timeout: strobes high for exactly `TIMEOUT`+1 cycles, then error completion.
- Data outputs hold their last value after valid until next completion for that port.

## Test plan
- Zero-wait fetch: `inst_rd_i`=1, addr 0x40, ack next cycle with 0x8C010004 → `bus_rd_o` 1 cycle later, `inst_valid_o` pulse with `inst_data_o`=0x8C010004, 3-cycle turnaround.
- Store: `data_we_i`=1, addr 0x100, data 0xCAFEBABE, sel 2'b10, ack after 3 wait cycles → bus fields match for 4 cycles, single `data_valid_o` pulse, `inst_valid_o` stays 0.
- Contention: both ports request continuously, `STARVE`=4 → grant order D,D,D,D,I,D,D,D,D,I.
- Timeout: `TIMEOUT`=8, load with no ack → strobe high 9 cycles, `data_valid_o` and `bus_err_o` pulse together, `data_data_o`=0.
- Reset mid-BUS: assert `rst` 2 cycles into a fetch → strobes 0 next edge, no `inst_valid_o`; late `bus_ack_i` ignored; post-reset fetch completes normally.
- Stray ack in IDLE with no requests → no state change, all outputs remain 0.
